// File: rtl/bnn_layer_engine_pkg.sv
// Shared types and helpers for the binary-NN layer engine.
package bnn_pkg;

  typedef enum logic [1:0] {
    WR_WEIGHT = 2'd0,
    WR_ACT    = 2'd1,
    WR_MASK   = 2'd2,
    WR_THR    = 2'd3
  } wr_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_OUT
  } state_e;

  // Width needed to hold a count of up to word_size*depth matching bits.
  function automatic int acc_width(input int word_size, input int depth);
    return $clog2(word_size * depth + 1);
  endfunction

endpackage

// File: rtl/bnn_layer_engine_if.sv
// Control, load and result bundle between host/downstream and the layer engine.
interface bnn_layer_engine_if
  import bnn_pkg::*;
#(
  parameter int NUM_PES   = 64,
  parameter int WORD_SIZE = 64,
  parameter int DEPTH     = 64,
  parameter int ACC_W     = acc_width(WORD_SIZE, DEPTH)
);

  logic                       start;
  logic [$clog2(DEPTH+1)-1:0] cfg_cols;
  logic                       cfg_binarize;
  logic                       abort;
  logic                       busy;
  logic                       done;
  logic                       wr_en;
  logic [1:0]                 wr_sel;
  logic [$clog2(NUM_PES)-1:0] wr_pe_idx;
  logic [$clog2(DEPTH)-1:0]   wr_addr;
  logic [WORD_SIZE-1:0]       wr_data;
  logic                       res_valid;
  logic                       res_ready;
  logic [NUM_PES*ACC_W-1:0]   res_counts;
  logic [NUM_PES-1:0]         res_bits;

  modport master (
    output start, cfg_cols, cfg_binarize, abort,
    output wr_en, wr_sel, wr_pe_idx, wr_addr, wr_data, res_ready,
    input  busy, done, res_valid, res_counts, res_bits
  );

  modport slave (
    input  start, cfg_cols, cfg_binarize, abort,
    input  wr_en, wr_sel, wr_pe_idx, wr_addr, wr_data, res_ready,
    output busy, done, res_valid, res_counts, res_bits
  );

endinterface

// File: rtl/bnn_layer_engine_pe.sv
// One XNOR-popcount processing element: masked match count, accumulator, threshold compare.
module bnn_xnor_pe #(
  parameter int WORD_SIZE = 64,
  parameter int ACC_W     = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_i,
  input  logic                 acc_en_i,
  input  logic [WORD_SIZE-1:0] weight_i,
  input  logic [WORD_SIZE-1:0] act_i,
  input  logic [WORD_SIZE-1:0] mask_i,
  input  logic [ACC_W-1:0]     thr_i,
  output logic [ACC_W-1:0]     acc_o,
  output logic                 ge_o
);

  logic [WORD_SIZE-1:0] match;
  logic [ACC_W-1:0]     pop;
  logic [ACC_W-1:0]     acc_q, acc_d;

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    match = ~(weight_i ^ act_i) & mask_i;
    pop   = ACC_W'($countones(match));
    acc_d = acc_q;
    if (clr_i)         acc_d = '0;
    else if (acc_en_i) acc_d = acc_q + pop;
  end

  // NOTE: non-blocking so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_o = acc_q;
  assign ge_o  = (acc_q >= thr_i);

endmodule

// File: rtl/bnn_layer_engine.sv
// Layer engine: weight/activation/mask/threshold storage, column sequencer and NUM_PES PEs.
module bnn_layer_engine
  import bnn_pkg::*;
#(
  parameter int NUM_PES   = 64,
  parameter int WORD_SIZE = 64,
  parameter int DEPTH     = 64,
  parameter int ACC_W     = acc_width(WORD_SIZE, DEPTH)
) (
  input logic               clk,
  input logic               reset,
  bnn_layer_engine_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WORD_SIZE-1:0] weight_mem [NUM_PES][DEPTH];
  logic [WORD_SIZE-1:0] act_mem    [DEPTH];
  logic [WORD_SIZE-1:0] mask_q     [DEPTH];
  logic [ACC_W-1:0]     thr_q      [NUM_PES];

  state_e        state_q, state_d;
  logic [AW-1:0] col_q, col_d;
  logic [CW-1:0] cols_q, cols_d;
  logic          binarize_q, binarize_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          pe_clr, pe_acc;
  logic          wr_ok;
  logic [NUM_PES-1:0] ge;

  assign wr_ok = bus.wr_en && (state_q == ST_IDLE);

  // NOTE: weight and activation arrays are bulk storage and carry no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      case (wr_sel_e'(bus.wr_sel))
        WR_WEIGHT: weight_mem[bus.wr_pe_idx][bus.wr_addr] <= bus.wr_data;
        WR_ACT:    act_mem[bus.wr_addr] <= bus.wr_data;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)   mask_q[i] <= '1;
      for (int i = 0; i < NUM_PES; i++) thr_q[i]  <= '0;
    end else if (wr_ok) begin
      case (wr_sel_e'(bus.wr_sel))
        WR_MASK: mask_q[bus.wr_addr]  <= bus.wr_data;
        WR_THR:  thr_q[bus.wr_pe_idx] <= bus.wr_data[ACC_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      cols_q     <= '0;
      binarize_q <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      cols_q     <= cols_d;
      binarize_q <= binarize_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    cols_d     = cols_q;
    binarize_d = binarize_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    pe_clr     = 1'b0;
    pe_acc     = 1'b0;
    // Abort wins over everything, including a result handshake on the same edge.
    if (state_q != ST_IDLE && bus.abort) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      col_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.start) begin
          cols_d     = bus.cfg_cols;
          binarize_d = bus.cfg_binarize;
          pe_clr     = 1'b1;
          state_d    = (bus.cfg_cols == '0) ? ST_OUT : ST_CLEAR;
        end
        ST_CLEAR: begin
          pe_clr  = 1'b1;
          col_d   = '0;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          pe_acc = 1'b1;
          col_d  = col_q + 1'b1;
          if (CW'(col_q) == cols_q - CW'(1)) begin
            col_d   = '0;
            state_d = ST_OUT;
          end
        end
        ST_OUT: begin
          if (!valid_q) begin
            valid_d = 1'b1;
          end else if (bus.res_ready) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_PES; k++) begin : g_pe
    bnn_xnor_pe #(
      .WORD_SIZE(WORD_SIZE),
      .ACC_W    (ACC_W)
    ) u_pe (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (pe_clr),
      .acc_en_i(pe_acc),
      .weight_i(weight_mem[k][col_q]),
      .act_i   (act_mem[col_q]),
      .mask_i  (mask_q[col_q]),
      .thr_i   (thr_q[k]),
      .acc_o   (bus.res_counts[k*ACC_W +: ACC_W]),
      .ge_o    (ge[k])
    );
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.res_valid = valid_q;
  assign bus.res_bits  = ge & {NUM_PES{binarize_q}};

endmodule

// File: tb/tb_bnn_layer_engine.sv
// Directed-vector bench for bnn_layer_engine at NUM_PES=4, WORD_SIZE=8, DEPTH=4.
module tb_bnn_layer_engine;

  localparam int NP = 4;
  localparam int WS = 8;
  localparam int DP = 4;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  bnn_layer_engine_if #(.NUM_PES(NP), .WORD_SIZE(WS), .DEPTH(DP)) bus ();

  bnn_layer_engine #(.NUM_PES(NP), .WORD_SIZE(WS), .DEPTH(DP)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  localparam logic [NP*AW-1:0] ALL32 = {6'd32, 6'd32, 6'd32, 6'd32};
  localparam logic [NP*AW-1:0] ALL8  = {6'd8, 6'd8, 6'd8, 6'd8};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input int pe, input int addr, input logic [7:0] data);
    bus.wr_en     = 1'b1;
    bus.wr_sel    = sel;
    bus.wr_pe_idx = pe[1:0];
    bus.wr_addr   = addr[1:0];
    bus.wr_data   = data;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic load_uniform(input logic [7:0] w, input logic [7:0] a, input logic [7:0] m);
    for (int c = 0; c < DP; c++) begin
      for (int k = 0; k < NP; k++) wr(2'd0, k, c, w);
      wr(2'd1, 0, c, a);
      wr(2'd2, 0, c, m);
    end
  endtask

  task automatic start_run(input int cols, input logic bin);
    bus.start        = 1'b1;
    bus.cfg_cols     = cols[2:0];
    bus.cfg_binarize = bin;
    tick();
    bus.start = 1'b0;
  endtask

  // Cycles from the start-accepting edge until res_valid is seen; 20 means it never came.
  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.res_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vectors++;
    if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", bus.done); end
    vectors++;
    if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.res_valid); end
    vectors++;
    if (bus.res_counts !== '0) begin miscompares++; $display("FAIL reset_counts: got %h want 0", bus.res_counts); end
    vectors++;
    if (bus.res_bits !== '0) begin miscompares++; $display("FAIL reset_bits: got %b want 0", bus.res_bits); end
  endtask

  task automatic test_full_run();
    int n;
    load_uniform(8'hFF, 8'hFF, 8'hFF);
    start_run(4, 1'b0);
    vectors++;
    if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL full_busy: got %b want 1", bus.busy); end
    wait_valid(n);
    vectors++;
    if (n != 6) begin miscompares++; $display("FAIL full_latency: got %0d want 6", n); end
    vectors++;
    if (bus.res_counts !== ALL32) begin miscompares++; $display("FAIL full_counts: got %h want %h", bus.res_counts, ALL32); end
    vectors++;
    if (bus.res_bits !== 4'b0000) begin miscompares++; $display("FAIL full_bits: got %b want 0000", bus.res_bits); end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    vectors++;
    if ({bus.done, bus.res_valid, bus.busy} !== 3'b100) begin
      miscompares++; $display("FAIL full_handshake: done/valid/busy got %b want 100", {bus.done, bus.res_valid, bus.busy});
    end
    tick();
    vectors++;
    if (bus.done !== 1'b0) begin miscompares++; $display("FAIL full_done_pulse: got %b want 0", bus.done); end
  endtask

  task automatic test_binarize();
    int n;
    wr(2'd3, 0, 0, 8'd10);
    wr(2'd3, 1, 0, 8'd32);
    wr(2'd3, 2, 0, 8'd33);
    wr(2'd3, 3, 0, 8'd0);
    start_run(4, 1'b1);
    wait_valid(n);
    vectors++;
    if (bus.res_counts !== ALL32) begin miscompares++; $display("FAIL bin_counts: got %h want %h", bus.res_counts, ALL32); end
    vectors++;
    if (bus.res_bits !== 4'b1011) begin miscompares++; $display("FAIL bin_bits: got %b want 1011", bus.res_bits); end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    start_run(4, 1'b1);
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if ({bus.res_valid, bus.busy, bus.done} !== 3'b110 || bus.res_counts !== ALL32 || bus.res_bits !== 4'b1011) begin
        miscompares++;
        $display("FAIL bp_hold%0d: valid/busy/done %b counts %h bits %b want 110 %h 1011",
                 i, {bus.res_valid, bus.busy, bus.done}, bus.res_counts, bus.res_bits, ALL32);
      end
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    vectors++;
    if ({bus.done, bus.busy} !== 2'b10) begin
      miscompares++; $display("FAIL bp_release: done/busy got %b want 10", {bus.done, bus.busy});
    end
  endtask

  task automatic test_partial_mask();
    int n;
    for (int c = 0; c < 2; c++) begin
      wr(2'd0, 0, c, 8'h0F);
      for (int k = 1; k < NP; k++) wr(2'd0, k, c, 8'h00);
      wr(2'd2, 0, c, 8'h3C);
    end
    start_run(2, 1'b0);
    wait_valid(n);
    vectors++;
    if (n != 4) begin miscompares++; $display("FAIL partial_latency: got %0d want 4", n); end
    vectors++;
    if (bus.res_counts !== {6'd0, 6'd0, 6'd0, 6'd4}) begin
      miscompares++; $display("FAIL partial_counts: got %h want %h", bus.res_counts, {6'd0, 6'd0, 6'd0, 6'd4});
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_abort_ignore();
    int n;
    load_uniform(8'hFF, 8'hFF, 8'hFF);
    start_run(4, 1'b0);
    tick();
    // In RUN: a second start and a weight write must both be dropped.
    bus.start     = 1'b1;
    bus.cfg_cols  = 3'd1;
    bus.wr_en     = 1'b1;
    bus.wr_sel    = 2'd0;
    bus.wr_pe_idx = 2'd0;
    bus.wr_addr   = 2'd3;
    bus.wr_data   = 8'h00;
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL abort_busy_run: got %b want 1", bus.busy); end
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    vectors++;
    if ({bus.busy, bus.res_valid, bus.done} !== 3'b000) begin
      miscompares++; $display("FAIL abort_idle: busy/valid/done got %b want 000", {bus.busy, bus.res_valid, bus.done});
    end
    tick();
    vectors++;
    if ({bus.busy, bus.res_valid, bus.done} !== 3'b000) begin
      miscompares++; $display("FAIL abort_quiet: busy/valid/done got %b want 000", {bus.busy, bus.res_valid, bus.done});
    end
    start_run(4, 1'b0);
    wait_valid(n);
    vectors++;
    if (n != 6 || bus.res_counts !== ALL32) begin
      miscompares++; $display("FAIL abort_rerun: latency %0d counts %h want 6 %h", n, bus.res_counts, ALL32);
    end
    bus.abort     = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    bus.abort     = 1'b0;
    bus.res_ready = 1'b0;
    vectors++;
    if ({bus.busy, bus.res_valid, bus.done} !== 3'b000) begin
      miscompares++; $display("FAIL abort_vs_ready: busy/valid/done got %b want 000", {bus.busy, bus.res_valid, bus.done});
    end
    tick();
    vectors++;
    if (bus.done !== 1'b0) begin miscompares++; $display("FAIL abort_no_done: got %b want 0", bus.done); end
  endtask

  task automatic test_edge_cases();
    int n;
    start_run(0, 1'b0);
    vectors++;
    if ({bus.busy, bus.res_valid} !== 2'b10) begin
      miscompares++; $display("FAIL cols0_accept: busy/valid got %b want 10", {bus.busy, bus.res_valid});
    end
    tick();
    vectors++;
    if (bus.res_valid !== 1'b1 || bus.res_counts !== '0) begin
      miscompares++; $display("FAIL cols0_result: valid %b counts %h want 1 0", bus.res_valid, bus.res_counts);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    vectors++;
    if (bus.done !== 1'b1) begin miscompares++; $display("FAIL cols0_done: got %b want 1", bus.done); end
    start_run(1, 1'b0);
    wait_valid(n);
    vectors++;
    if (n != 3 || bus.res_counts !== ALL8) begin
      miscompares++; $display("FAIL cols1_result: latency %0d counts %h want 3 %h", n, bus.res_counts, ALL8);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({bus.res_valid, bus.busy, bus.res_bits} !== 6'b0 || bus.res_counts !== '0) begin
      miscompares++; $display("FAIL reset_in_out: valid %b busy %b bits %b counts %h want all 0",
                              bus.res_valid, bus.busy, bus.res_bits, bus.res_counts);
    end
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.cfg_cols     = '0;
    bus.cfg_binarize = 1'b0;
    bus.abort        = 1'b0;
    bus.wr_en        = 1'b0;
    bus.wr_sel       = '0;
    bus.wr_pe_idx    = '0;
    bus.wr_addr      = '0;
    bus.wr_data      = '0;
    bus.res_ready    = 1'b0;
    test_reset();
    test_full_run();
    test_binarize();
    test_backpressure();
    test_partial_mask();
    test_abort_ignore();
    test_edge_cases();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
